// File: rtl/pool_window_gen.sv
// Streaming KxK window generator for pooled feature planes.
// Line buffers hold the previous K-1 rows; a shift register holds the active window.
module pool_window_gen #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_COLUMNS = 14,
  parameter int unsigned NUM_ROWS    = 14,
  parameter int unsigned KERNEL_SIZE = 5
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst_n,
  input  logic                                              i_valid,
  input  logic signed [DATA_WIDTH-1:0]                      i_features,
  output logic                                              o_valid,
  output logic                                              o_last,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     o_window
);

  localparam int unsigned ColW   = $clog2(NUM_COLUMNS);
  localparam int unsigned RowW   = $clog2(NUM_ROWS);
  localparam int unsigned WinW   = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;

  localparam logic [ColW-1:0] ColStart = ColW'(KERNEL_SIZE - 1);
  localparam logic [ColW-1:0] ColLast  = ColW'(NUM_COLUMNS - 1);
  localparam logic [RowW-1:0] RowStart = RowW'(KERNEL_SIZE - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(NUM_ROWS - 1);

  logic [ColW-1:0]       col_cnt_q, col_cnt_d;
  logic [RowW-1:0]       row_cnt_q, row_cnt_d;
  logic [DATA_WIDTH-1:0] lb_q   [KERNEL_SIZE-1][NUM_COLUMNS];
  logic [DATA_WIDTH-1:0] col_vec[KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] win_q  [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_WIDTH-1:0] win_d  [KERNEL_SIZE][KERNEL_SIZE];
  logic [WinW-1:0]       window_flat;
  logic [WinW-1:0]       o_window_q;
  logic                  o_valid_q, o_last_q;
  logic                  emit, last;

  // Column entering the window: buffered rows on top, live feature at the bottom.
  always_comb begin
    for (int unsigned r = 0; r < KERNEL_SIZE - 1; r++) begin
      col_vec[r] = lb_q[r][col_cnt_q];
    end
    col_vec[KERNEL_SIZE-1] = i_features;
  end

  always_comb begin
    for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
      for (int unsigned c = 0; c < KERNEL_SIZE - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][KERNEL_SIZE-1] = col_vec[r];
    end
  end

  always_comb begin
    window_flat = '0;
    for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
      for (int unsigned c = 0; c < KERNEL_SIZE; c++) begin
        window_flat[(r*KERNEL_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
      end
    end
  end

  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (i_valid) begin
      if (col_cnt_q == ColLast) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == RowLast) ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
    end
  end

  // Counter gating keeps windows straddling a row or a plane boundary hidden.
  assign emit = i_valid && (row_cnt_q >= RowStart) && (col_cnt_q >= ColStart);
  assign last = emit && (row_cnt_q == RowLast) && (col_cnt_q == ColLast);

  // Data storage is intentionally left unreset.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      for (int unsigned k = 0; k < KERNEL_SIZE - 2; k++) begin
        lb_q[k][col_cnt_q] <= lb_q[k+1][col_cnt_q];
      end
      lb_q[KERNEL_SIZE-2][col_cnt_q] <= i_features;
      win_q <= win_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_window_q <= '0;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      o_valid_q <= emit;
      o_last_q  <= last;
      if (emit) begin
        o_window_q <= window_flat;
      end
    end
  end

  assign o_valid  = o_valid_q;
  assign o_last   = o_last_q;
  assign o_window = o_window_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Randomised and directed checks of pool_window_gen against a plane-image reference model.
module tb_pool_window_gen;

  localparam int DW = 16;
  localparam int NC = 14;
  localparam int NR = 14;
  localparam int K  = 5;
  localparam int W  = K * K * DW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_feat;
  logic          out_valid;
  logic          out_last;
  logic [W-1:0]  out_window;

  pool_window_gen #(
    .DATA_WIDTH (DW),
    .NUM_COLUMNS(NC),
    .NUM_ROWS   (NR),
    .KERNEL_SIZE(K)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (in_valid),
    .i_features(in_feat),
    .o_valid   (out_valid),
    .o_last    (out_last),
    .o_window  (out_window)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the plane as a 2-D image, windows cut straight out of it.
  logic [DW-1:0] img [NR][NC];
  int            rp, cp;
  logic          exp_valid, exp_last;
  logic [W-1:0]  exp_win;

  // Observed statistics per test section.
  int            n_pulses, n_last, n_b2b, feat_cnt, first_pulse_feat;
  logic          prev_valid;
  logic [W-1:0]  dut_wins[$];
  logic [W-1:0]  ramp_wins[$];
  logic [W-1:0]  sig_exp;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] elem(input logic [W-1:0] w, input int r, input int c);
    return w[(r*K+c)*DW +: DW];
  endfunction

  task automatic clear_stats();
    n_pulses = 0;
    n_last = 0;
    n_b2b = 0;
    feat_cnt = 0;
    first_pulse_feat = -1;
    prev_valid = 1'b0;
    dut_wins.delete();
  endtask

  task automatic model_reset();
    rp = 0;
    cp = 0;
    exp_valid = 1'b0;
    exp_last = 1'b0;
    exp_win = '0;
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d);
    in_valid = v;
    in_feat = d;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_valid = 1'b0;
      exp_last = 1'b0;
      if (v) begin
        feat_cnt++;
        img[rp][cp] = d;
        if (rp >= K - 1 && cp >= K - 1) begin
          exp_valid = 1'b1;
          exp_last = (rp == NR - 1) && (cp == NC - 1);
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              exp_win[(i*K+j)*DW +: DW] = img[rp-K+1+i][cp-K+1+j];
        end
        cp++;
        if (cp == NC) begin
          cp = 0;
          rp++;
          if (rp == NR) rp = 0;
        end
      end
    end
    #1;
    check_eq("o_valid", out_valid, exp_valid);
    check_eq("o_last", out_last, exp_last);
    check_eq("o_window", out_window, exp_win);
    if (out_valid) begin
      dut_wins.push_back(out_window);
      n_pulses++;
      if (out_last) n_last++;
      if (prev_valid) n_b2b++;
      if (first_pulse_feat < 0) first_pulse_feat = feat_cnt;
    end
    prev_valid = out_valid;
  endtask

  // kind: 0 ramp (+offset), 1 signed extremes, 2 random. gap: 0 none, 1 every 3rd, 2 random.
  task automatic send_plane(input int kind, input int offset, input int gap, input int nfeat);
    int idx;
    logic [DW-1:0] d;
    int idle;
    idx = 0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (idx < nfeat) begin
          case (kind)
            0:       d = DW'(offset + r * NC + c);
            1:       d = (r == 4 && c == 4) ? 16'h7fff : 16'h8000;
            default: d = DW'($urandom);
          endcase
          step(1'b1, d);
          idle = (gap == 1) ? 2 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
          for (int g = 0; g < idle; g++) step(1'b0, DW'($urandom));
          idx++;
        end
      end
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_async_valid", out_valid, 1'b0);
    check_eq("rst_async_last", out_last, 1'b0);
    check_eq("rst_async_window", out_window, '0);
    for (int i = 0; i < cycles; i++) step(1'($urandom), DW'($urandom));
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_feat = '0;
    model_reset();
    clear_stats();

    // Reset held with i_valid toggling
    for (int i = 0; i < 6; i++) step(1'($urandom), DW'($urandom));
    rst_n = 1'b1;

    // Contiguous ramp plane
    clear_stats();
    send_plane(0, 0, 0, NR * NC);
    check_eq("ramp_count", n_pulses, 100);
    check_eq("ramp_lasts", n_last, 1);
    check_eq("ramp_first_feat", first_pulse_feat, 61);
    if (dut_wins.size() == 100) begin
      check_eq("ramp_first_00", elem(dut_wins[0], 0, 0), 16'd0);
      check_eq("ramp_first_23", elem(dut_wins[0], 2, 3), 16'd31);
      check_eq("ramp_first_44", elem(dut_wins[0], 4, 4), 16'd60);
      check_eq("ramp_final_00", elem(dut_wins[99], 0, 0), 16'd135);
      check_eq("ramp_final_44", elem(dut_wins[99], 4, 4), 16'd195);
    end
    ramp_wins = dut_wins;

    // Ramp with i_valid every 3rd cycle
    clear_stats();
    send_plane(0, 0, 1, NR * NC);
    check_eq("gap_count", n_pulses, 100);
    check_eq("gap_b2b", n_b2b, 0);
    check_eq("gap_lasts", n_last, 1);
    if (dut_wins.size() == ramp_wins.size())
      foreach (dut_wins[i]) check_eq("gap_seq", dut_wins[i], ramp_wins[i]);

    // Two ramp planes back-to-back
    clear_stats();
    send_plane(0, 0, 0, NR * NC);
    send_plane(0, 1000, 0, NR * NC);
    check_eq("b2b_count", n_pulses, 200);
    check_eq("b2b_lasts", n_last, 2);
    if (dut_wins.size() == 200) begin
      check_eq("plane2_first_00", elem(dut_wins[100], 0, 0), 16'd1000);
      check_eq("plane2_first_44", elem(dut_wins[100], 4, 4), 16'd1060);
    end

    // Reset mid-plane, then a full ramp plane
    send_plane(0, 0, 0, 70);
    apply_reset(3);
    clear_stats();
    send_plane(0, 0, 0, NR * NC);
    check_eq("mid_rst_count", n_pulses, 100);
    check_eq("mid_rst_lasts", n_last, 1);
    if (dut_wins.size() == ramp_wins.size())
      foreach (dut_wins[i]) check_eq("mid_rst_seq", dut_wins[i], ramp_wins[i]);

    // Signed pass-through
    clear_stats();
    send_plane(1, 0, 0, NR * NC);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        sig_exp[(i*K+j)*DW +: DW] = (i == 4 && j == 4) ? 16'h7fff : 16'h8000;
    check_eq("signed_count", n_pulses, 100);
    if (dut_wins.size() > 0) check_eq("signed_first", dut_wins[0], sig_exp);

    // Random data with random idle gaps
    clear_stats();
    for (int p = 0; p < 3; p++) send_plane(2, 0, 2, NR * NC);
    check_eq("rand_count", n_pulses, 300);
    check_eq("rand_lasts", n_last, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
